// File: rtl/fse_pkg.sv
// Shared types, defaults and helpers for the FSE sequencer and tap banks.
package fse_pkg;

    localparam int unsigned NBT_TAPS_DEF = 28;
    localparam int unsigned NBF_TAPS_DEF = 25;

    typedef enum logic [0:0] {
        StFill = 1'b0,
        StRun  = 1'b1
    } fse_state_e;

    // cfg address width: tap index bits plus one bank-select MSB
    function automatic int unsigned calc_nb_addr(input int unsigned num_taps);
        return $clog2(num_taps) + 1;
    endfunction

    // Unity gain in S(NBT,NBF) format; callers slice to the tap width
    function automatic logic [63:0] tap_centre(input int unsigned nbf_taps);
        return 64'd1 << nbf_taps;
    endfunction

endpackage

// File: rtl/fse_tap_bank.sv
// Double-buffered tap register file: host writes the shadow copy, a swap strobe
// copies the whole shadow copy into the active copy in one cycle.
module fse_tap_bank
    import fse_pkg::*;
#(
    parameter int unsigned NUM_TAPS   = 9,
    parameter int unsigned NBT_TAPS   = NBT_TAPS_DEF,
    parameter int unsigned NBF_TAPS   = NBF_TAPS_DEF,
    parameter bit          CENTRE_ONE = 1'b0,
    parameter int unsigned IDX_W      = calc_nb_addr(NUM_TAPS) - 1
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_we,
    input  logic [IDX_W-1:0]             i_idx,
    input  logic [NBT_TAPS-1:0]          i_data,
    input  logic                         i_swap,
    output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps
);

    localparam int unsigned         CENTRE      = NUM_TAPS / 2;
    localparam logic [63:0]         CENTRE_WORD = tap_centre(NBF_TAPS);
    localparam logic [NBT_TAPS-1:0] CENTRE_VAL  = CENTRE_WORD[NBT_TAPS-1:0];

    logic [NBT_TAPS-1:0] shadow_q [NUM_TAPS];
    logic [NBT_TAPS-1:0] active_q [NUM_TAPS];

    // Shadow write port and shadow->active swap; both copies reset to the same default
    always_ff @(posedge clk) begin
        for (int j = 0; j < int'(NUM_TAPS); j++) begin
            if (!i_reset) begin
                shadow_q[j] <= (CENTRE_ONE && j == int'(CENTRE)) ? CENTRE_VAL : '0;
                active_q[j] <= (CENTRE_ONE && j == int'(CENTRE)) ? CENTRE_VAL : '0;
            end else begin
                if (i_we && int'(i_idx) == j) begin
                    shadow_q[j] <= i_data;
                end
                if (i_swap) begin
                    active_q[j] <= shadow_q[j];
                end
            end
        end
    end

    // Pack the active copy, tap j in slice j
    always_comb begin
        o_taps = '0;
        for (int j = 0; j < int'(NUM_TAPS); j++) begin
            o_taps[j*NBT_TAPS +: NBT_TAPS] = active_q[j];
        end
    end

endmodule

// File: rtl/fse_ctrl.sv
// Sequencer and coefficient manager for the 2-samples/symbol complex FSE:
// shift enable, polyphase tracking, fill detection, symbol-valid and tap swaps.
module fse_ctrl
    import fse_pkg::*;
#(
    parameter int unsigned NUM_TAPS = 9,
    parameter int unsigned NBT_TAPS = NBT_TAPS_DEF,
    parameter int unsigned NBF_TAPS = NBF_TAPS_DEF,
    parameter int unsigned NB_ADDR  = calc_nb_addr(NUM_TAPS)
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_valid,
    input  logic                         i_phase_sel,
    input  logic                         i_cfg_we,
    input  logic [NB_ADDR-1:0]           i_cfg_addr,
    input  logic [NBT_TAPS-1:0]          i_cfg_data,
    input  logic                         i_cfg_commit,
    output logic                         o_fse_en,
    output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_I,
    output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_Q,
    output logic                         o_sym_valid,
    output logic                         o_phase,
    output logic                         o_filled,
    output logic                         o_cfg_busy
);

    localparam int unsigned      IDX_W    = NB_ADDR - 1;
    localparam int unsigned      CNT_W    = $clog2(NUM_TAPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TAPS - 1);

    fse_state_e       state_q;
    logic [CNT_W-1:0] fill_cnt_q;
    logic             phase_q;
    logic             sym_valid_q;
    logic             pending_q;

    logic sample_phase;
    logic idx_ok;
    logic wr_en;
    logic we_i;
    logic we_q;
    logic swap;

    // Write decode and swap timing: while filling nothing is being output, so swap at once
    always_comb begin
        sample_phase = ~phase_q;
        idx_ok       = int'(i_cfg_addr[IDX_W-1:0]) < int'(NUM_TAPS);
        wr_en        = i_cfg_we & ~pending_q & idx_ok;
        we_i         = wr_en & ~i_cfg_addr[NB_ADDR-1];
        we_q         = wr_en & i_cfg_addr[NB_ADDR-1];
        swap         = pending_q & ((state_q == StFill) |
                                    (i_valid & (sample_phase != i_phase_sel)));
    end

    // FSM, phase tracking, fill count, symbol-valid and commit-pending registers
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_q     <= StFill;
            fill_cnt_q  <= '0;
            phase_q     <= 1'b1;
            sym_valid_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            sym_valid_q <= i_valid & (sample_phase == i_phase_sel) &
                           ((state_q == StRun) |
                            ((state_q == StFill) & (fill_cnt_q == LAST_CNT)));
            if (i_valid) begin
                phase_q <= sample_phase;
            end
            case (state_q)
                StFill: begin
                    if (i_valid) begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        if (fill_cnt_q == LAST_CNT) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun:   state_q <= StRun;
                default: state_q <= StFill;
            endcase
            // A commit on the swap edge re-arms for the next boundary
            if (i_cfg_commit) begin
                pending_q <= 1'b1;
            end else if (swap) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign o_fse_en    = i_valid & i_reset;
    assign o_sym_valid = sym_valid_q;
    assign o_phase     = phase_q;
    assign o_filled    = (state_q == StRun);
    assign o_cfg_busy  = pending_q;

    fse_tap_bank #(
        .NUM_TAPS   (NUM_TAPS),
        .NBT_TAPS   (NBT_TAPS),
        .NBF_TAPS   (NBF_TAPS),
        .CENTRE_ONE (1'b1),
        .IDX_W      (IDX_W)
    ) u_bank_i (
        .clk     (clk),
        .i_reset (i_reset),
        .i_we    (we_i),
        .i_idx   (i_cfg_addr[IDX_W-1:0]),
        .i_data  (i_cfg_data),
        .i_swap  (swap),
        .o_taps  (o_taps_I)
    );

    fse_tap_bank #(
        .NUM_TAPS   (NUM_TAPS),
        .NBT_TAPS   (NBT_TAPS),
        .NBF_TAPS   (NBF_TAPS),
        .CENTRE_ONE (1'b0),
        .IDX_W      (IDX_W)
    ) u_bank_q (
        .clk     (clk),
        .i_reset (i_reset),
        .i_we    (we_q),
        .i_idx   (i_cfg_addr[IDX_W-1:0]),
        .i_data  (i_cfg_data),
        .i_swap  (swap),
        .o_taps  (o_taps_Q)
    );

endmodule

// File: tb/tb_fse_ctrl.sv
// Directed bench for fse_ctrl: reset, fill, symbol-valid cadence, tap commit/swap rules.
module tb_fse_ctrl;

    localparam int unsigned NUM_TAPS = 9;
    localparam int unsigned NBT      = 28;
    localparam int unsigned NB_ADDR  = 5;
    localparam int unsigned TW       = NUM_TAPS * NBT;

    logic               clk = 1'b0;
    logic               i_reset = 1'b0;
    logic               i_valid = 1'b0;
    logic               i_phase_sel = 1'b1;
    logic               i_cfg_we = 1'b0;
    logic [NB_ADDR-1:0] i_cfg_addr = '0;
    logic [NBT-1:0]     i_cfg_data = '0;
    logic               i_cfg_commit = 1'b0;
    logic               o_fse_en;
    logic [TW-1:0]      o_taps_I;
    logic [TW-1:0]      o_taps_Q;
    logic               o_sym_valid;
    logic               o_phase;
    logic               o_filled;
    logic               o_cfg_busy;

    int errors = 0;
    int checks = 0;
    logic [TW-1:0] exp_i;
    logic [TW-1:0] exp_q;

    fse_ctrl #(
        .NUM_TAPS (NUM_TAPS),
        .NBT_TAPS (NBT),
        .NBF_TAPS (25),
        .NB_ADDR  (NB_ADDR)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_phase_sel  (i_phase_sel),
        .i_cfg_we     (i_cfg_we),
        .i_cfg_addr   (i_cfg_addr),
        .i_cfg_data   (i_cfg_data),
        .i_cfg_commit (i_cfg_commit),
        .o_fse_en     (o_fse_en),
        .o_taps_I     (o_taps_I),
        .o_taps_Q     (o_taps_Q),
        .o_sym_valid  (o_sym_valid),
        .o_phase      (o_phase),
        .o_filled     (o_filled),
        .o_cfg_busy   (o_cfg_busy)
    );

    always #5 clk = ~clk;

    task automatic chkv(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
        end
    endtask

    // Advance one clock; outputs are read 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [NB_ADDR-1:0] a, input logic [NBT-1:0] d);
        i_cfg_we   = 1'b1;
        i_cfg_addr = a;
        i_cfg_data = d;
        step();
        i_cfg_we   = 1'b0;
    endtask

    task automatic commit();
        i_cfg_commit = 1'b1;
        step();
        i_cfg_commit = 1'b0;
    endtask

    // Fill with a sample every other cycle; sample k has phase (k-1)%2, sel=1
    task automatic fill_run(input int n, input string pfx);
        for (int k = 1; k <= n; k++) begin
            sample();
            chk1($sformatf("%s_symv_k%0d", pfx, k), o_sym_valid, (k >= 10) && (k % 2 == 0));
            chk1($sformatf("%s_filled_k%0d", pfx, k), o_filled, k >= 9);
            chk1($sformatf("%s_phase_k%0d", pfx, k), o_phase, k % 2 == 0);
            step();
            chk1($sformatf("%s_symv_off_k%0d", pfx, k), o_sym_valid, 1'b0);
        end
    endtask

    initial begin
        // 1. reset state
        step();
        step();
        i_reset = 1'b1;
        exp_i = '0;
        exp_i[4*NBT +: NBT] = 28'h2000000;
        exp_q = '0;
        chkv("rst_taps_i", o_taps_I, exp_i);
        chkv("rst_taps_q", o_taps_Q, exp_q);
        chk1("rst_symv", o_sym_valid, 1'b0);
        chk1("rst_filled", o_filled, 1'b0);
        chk1("rst_busy", o_cfg_busy, 1'b0);
        chk1("rst_phase", o_phase, 1'b1);
        chk1("rst_fse_en", o_fse_en, 1'b0);
        i_valid = 1'b1;
        #1;
        chk1("fse_en_valid", o_fse_en, 1'b1);
        i_valid = 1'b0;
        #1;
        chk1("fse_en_idle", o_fse_en, 1'b0);

        // 2. fill: 15 samples, pulses after samples 10, 12, 14
        fill_run(15, "fill");

        // 3. write I tap0 and Q tap8, commit; next sample is phase 1 (no swap)
        cfg_write(5'h00, 28'h0123456);
        cfg_write(5'h18, 28'hFF00000);
        commit();
        chk1("c1_busy", o_cfg_busy, 1'b1);
        chkv("c1_taps_i_held", o_taps_I, exp_i);
        sample();                          // sample 16, phase 1
        chk1("c1_s16_symv", o_sym_valid, 1'b1);
        chkv("c1_s16_taps_i", o_taps_I, exp_i);
        chk1("c1_s16_busy", o_cfg_busy, 1'b1);
        step();
        sample();                          // sample 17, phase 0 -> swap
        exp_i[0 +: NBT]     = 28'h0123456;
        exp_q[8*NBT +: NBT] = 28'hFF00000;
        chkv("c1_swap_taps_i", o_taps_I, exp_i);
        chkv("c1_swap_taps_q", o_taps_Q, exp_q);
        chk1("c1_swap_busy", o_cfg_busy, 1'b0);
        chk1("c1_swap_symv", o_sym_valid, 1'b0);
        step();
        sample();                          // sample 18
        chk1("c1_s18_symv", o_sym_valid, 1'b1);
        step();

        // 4. dropped writes: while busy, and out-of-range indices
        commit();
        cfg_write(5'h01, 28'h7777777);
        sample();                          // sample 19, phase 0 -> swap
        chk1("c2_swap_busy", o_cfg_busy, 1'b0);
        chkv("c2_taps_i", o_taps_I, exp_i);
        chkv("c2_taps_q", o_taps_Q, exp_q);
        step();
        cfg_write(5'd9, 28'h1111111);
        cfg_write(5'd31, 28'h2222222);
        commit();
        sample();                          // sample 20
        chk1("c3_s20_symv", o_sym_valid, 1'b1);
        step();
        sample();                          // sample 21 -> swap
        chk1("c3_swap_busy", o_cfg_busy, 1'b0);
        chkv("c3_taps_i", o_taps_I, exp_i);
        chkv("c3_taps_q", o_taps_Q, exp_q);
        step();

        // 5. write and commit together; then commit coinciding with the swap edge
        i_cfg_we     = 1'b1;
        i_cfg_addr   = 5'h02;
        i_cfg_data   = 28'h1000000;
        i_cfg_commit = 1'b1;
        step();
        i_cfg_we     = 1'b0;
        i_cfg_commit = 1'b0;
        chk1("c4_busy", o_cfg_busy, 1'b1);
        sample();                          // sample 22, phase 1
        chkv("c4_s22_taps_i", o_taps_I, exp_i);
        chk1("c4_s22_symv", o_sym_valid, 1'b1);
        step();
        i_cfg_commit = 1'b1;
        sample();                          // sample 23, swap plus new commit
        i_cfg_commit = 1'b0;
        exp_i[2*NBT +: NBT] = 28'h1000000;
        chkv("c4_swap_taps_i", o_taps_I, exp_i);
        chk1("c4_rearm_busy", o_cfg_busy, 1'b1);
        step();
        sample();                          // sample 24
        chk1("c4_s24_busy", o_cfg_busy, 1'b1);
        step();
        sample();                          // sample 25 -> second swap
        chk1("c4_s25_busy", o_cfg_busy, 1'b0);
        chkv("c4_s25_taps_i", o_taps_I, exp_i);
        step();

        // 6. reset mid-RUN with a commit pending
        commit();
        chk1("r_pre_busy", o_cfg_busy, 1'b1);
        i_reset = 1'b0;
        i_valid = 1'b1;
        #1;
        chk1("r_fse_en_in_reset", o_fse_en, 1'b0);
        step();
        i_valid = 1'b0;
        i_reset = 1'b1;
        exp_i = '0;
        exp_i[4*NBT +: NBT] = 28'h2000000;
        exp_q = '0;
        chk1("r_filled", o_filled, 1'b0);
        chk1("r_busy", o_cfg_busy, 1'b0);
        chk1("r_phase", o_phase, 1'b1);
        chk1("r_symv", o_sym_valid, 1'b0);
        chkv("r_taps_i", o_taps_I, exp_i);
        chkv("r_taps_q", o_taps_Q, exp_q);

        // Commit during fill swaps on the very next edge, no sample needed
        cfg_write(5'h03, 28'h0000005);
        commit();
        chk1("f_busy", o_cfg_busy, 1'b1);
        step();
        exp_i[3*NBT +: NBT] = 28'h0000005;
        chk1("f_swap_busy", o_cfg_busy, 1'b0);
        chkv("f_swap_taps_i", o_taps_I, exp_i);

        fill_run(10, "refill");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
